// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - write/read/status bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              clr_err;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              w_afull;
    logic              r_en;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_empty;
    logic              r_aempty;
    logic [ADDR_W:0]   fill_cnt;
    logic              overflow;
    logic              underflow;

    modport master (
        output clr_err, w_en, w_data, r_en,
        input  w_full, w_afull, r_data, r_valid, r_empty, r_aempty,
               fill_cnt, overflow, underflow
    );

    modport slave (
        input  clr_err, w_en, w_data, r_en,
        output w_full, w_afull, r_data, r_valid, r_empty, r_aempty,
               fill_cnt, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with thresholds, registered read and sticky errors
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic clk,
    input  logic rst,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_V  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_V = AEMPTY_TH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              full_q;
    logic              afull_q;
    logic              empty_q;
    logic              aempty_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic              ovf_q;
    logic              udf_q;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance uses the registered flags, so at full a read wins and at empty a write wins.
    assign wr_ok = bus.w_en & ~full_q;
    assign rd_ok = bus.r_en & ~empty_q;

    always_comb begin
        cnt_nxt = cnt;
        if (wr_ok && !rd_ok)
            cnt_nxt = cnt + 1'b1;
        else if (rd_ok && !wr_ok)
            cnt_nxt = cnt - 1'b1;
    end

    // Storage keeps its contents across reset; only the write port touches it.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wptr] <= bus.w_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr    <= rptr + 1'b1;
                rdata_q <= mem[rptr];
            end
            rvalid_q <= rd_ok;
            cnt      <= cnt_nxt;
            full_q   <= (cnt_nxt == DEPTH_V);
            afull_q  <= (cnt_nxt >= AFULL_V);
            empty_q  <= (cnt_nxt == '0);
            aempty_q <= (cnt_nxt <= AEMPTY_V);
            // A new error in the same cycle as clr_err keeps the flag set.
            if (bus.w_en && full_q)
                ovf_q <= 1'b1;
            else if (bus.clr_err)
                ovf_q <= 1'b0;
            if (bus.r_en && empty_q)
                udf_q <= 1'b1;
            else if (bus.clr_err)
                udf_q <= 1'b0;
        end
    end

    assign bus.w_full    = full_q;
    assign bus.w_afull   = afull_q;
    assign bus.r_empty   = empty_q;
    assign bus.r_aempty  = aempty_q;
    assign bus.r_data    = rdata_q;
    assign bus.r_valid   = rvalid_q;
    assign bus.fill_cnt  = cnt;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    sync_fifo_param_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    sync_fifo_param #(.DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.w_en = 1'b0; bus.r_en = 1'b0; bus.clr_err = 1'b0; bus.w_data = 8'h00;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (bus.r_empty !== 1'b1) $display("FAIL reset_r_empty got %b exp 1", bus.r_empty); else passed++;
        total++; if (bus.r_aempty !== 1'b1) $display("FAIL reset_r_aempty got %b exp 1", bus.r_aempty); else passed++;
        total++; if (bus.w_full !== 1'b0) $display("FAIL reset_w_full got %b exp 0", bus.w_full); else passed++;
        total++; if (bus.w_afull !== 1'b0) $display("FAIL reset_w_afull got %b exp 0", bus.w_afull); else passed++;
        total++; if (bus.fill_cnt !== 4'd0) $display("FAIL reset_fill_cnt got %0d exp 0", bus.fill_cnt); else passed++;
        total++; if (bus.r_valid !== 1'b0) $display("FAIL reset_r_valid got %b exp 0", bus.r_valid); else passed++;
        total++; if (bus.r_data !== 8'h00) $display("FAIL reset_r_data got %h exp 00", bus.r_data); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", bus.overflow); else passed++;
        total++; if (bus.underflow !== 1'b0) $display("FAIL reset_underflow got %b exp 0", bus.underflow); else passed++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            bus.w_en = 1'b1; bus.w_data = 8'h11 + 8'(i);
            tick();
            total++; if (bus.fill_cnt !== 4'(i + 1)) $display("FAIL fill_cnt_%0d got %0d exp %0d", i, bus.fill_cnt, i + 1); else passed++;
            total++; if (bus.w_afull !== (i + 1 >= 6)) $display("FAIL fill_afull_%0d got %b exp %b", i, bus.w_afull, i + 1 >= 6); else passed++;
            total++; if (bus.w_full !== (i + 1 == 8)) $display("FAIL fill_full_%0d got %b exp %b", i, bus.w_full, i + 1 == 8); else passed++;
            total++; if (bus.r_aempty !== (i + 1 <= 1)) $display("FAIL fill_aempty_%0d got %b exp %b", i, bus.r_aempty, i + 1 <= 1); else passed++;
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            bus.r_en = 1'b1;
            tick();
            total++; if (bus.r_valid !== 1'b1) $display("FAIL drain_valid_%0d got %b exp 1", i, bus.r_valid); else passed++;
            total++; if (bus.r_data !== 8'h11 + 8'(i)) $display("FAIL drain_data_%0d got %h exp %h", i, bus.r_data, 8'h11 + 8'(i)); else passed++;
            total++; if (bus.fill_cnt !== 4'(7 - i)) $display("FAIL drain_cnt_%0d got %0d exp %0d", i, bus.fill_cnt, 7 - i); else passed++;
        end
        idle();
        tick();
        total++; if (bus.r_empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", bus.r_empty); else passed++;
        total++; if (bus.r_valid !== 1'b0) $display("FAIL drain_idle_valid got %b exp 0", bus.r_valid); else passed++;
        total++; if (bus.r_data !== 8'h18) $display("FAIL drain_hold_data got %h exp 18", bus.r_data); else passed++;
        total++; if (bus.underflow !== 1'b0) $display("FAIL drain_underflow got %b exp 0", bus.underflow); else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            bus.w_en = 1'b1; bus.w_data = 8'h11 + 8'(i);
            tick();
        end
        bus.w_data = 8'hAA;
        tick();
        idle();
        total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", bus.overflow); else passed++;
        total++; if (bus.fill_cnt !== 4'd8) $display("FAIL ovf_cnt got %0d exp 8", bus.fill_cnt); else passed++;
        bus.r_en = 1'b1;
        tick();
        idle();
        total++; if (bus.r_data !== 8'h11) $display("FAIL ovf_first_data got %h exp 11", bus.r_data); else passed++;
        total++; if (bus.r_valid !== 1'b1) $display("FAIL ovf_first_valid got %b exp 1", bus.r_valid); else passed++;
        total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.overflow); else passed++;
        bus.clr_err = 1'b1;
        tick();
        idle();
        total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear got %b exp 0", bus.overflow); else passed++;
        for (int i = 1; i < 8; i++) begin
            bus.r_en = 1'b1;
            tick();
            total++; if (bus.r_data !== 8'h11 + 8'(i)) $display("FAIL ovf_drain_%0d got %h exp %h", i, bus.r_data, 8'h11 + 8'(i)); else passed++;
        end
        idle();
        tick();
        total++; if (bus.r_empty !== 1'b1) $display("FAIL ovf_end_empty got %b exp 1", bus.r_empty); else passed++;
    endtask

    task automatic test_empty_simul();
        bus.w_en = 1'b1; bus.r_en = 1'b1; bus.w_data = 8'h5C;
        tick();
        total++; if (bus.fill_cnt !== 4'd1) $display("FAIL emp_cnt got %0d exp 1", bus.fill_cnt); else passed++;
        total++; if (bus.r_valid !== 1'b0) $display("FAIL emp_valid got %b exp 0", bus.r_valid); else passed++;
        total++; if (bus.underflow !== 1'b1) $display("FAIL emp_underflow got %b exp 1", bus.underflow); else passed++;
        bus.w_en = 1'b0;
        tick();
        idle();
        total++; if (bus.r_data !== 8'h5C) $display("FAIL emp_data got %h exp 5c", bus.r_data); else passed++;
        total++; if (bus.r_valid !== 1'b1) $display("FAIL emp_data_valid got %b exp 1", bus.r_valid); else passed++;
        total++; if (bus.fill_cnt !== 4'd0) $display("FAIL emp_cnt_after got %0d exp 0", bus.fill_cnt); else passed++;
        bus.clr_err = 1'b1;
        tick();
        idle();
        total++; if (bus.underflow !== 1'b0) $display("FAIL emp_clear got %b exp 0", bus.underflow); else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) begin
            bus.w_en = 1'b1; bus.w_data = 8'h20 + 8'(i);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            bus.w_en = 1'b1; bus.r_en = 1'b1; bus.w_data = 8'h24 + 8'(i);
            tick();
            total++; if (bus.fill_cnt !== 4'd4) $display("FAIL wrap_cnt_%0d got %0d exp 4", i, bus.fill_cnt); else passed++;
            total++; if (bus.r_data !== 8'h20 + 8'(i) || bus.r_valid !== 1'b1) $display("FAIL wrap_data_%0d got %h/%b exp %h/1", i, bus.r_data, bus.r_valid, 8'h20 + 8'(i)); else passed++;
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            bus.r_en = 1'b1;
            tick();
            total++; if (bus.r_data !== 8'h34 + 8'(i)) $display("FAIL wrap_tail_%0d got %h exp %h", i, bus.r_data, 8'h34 + 8'(i)); else passed++;
        end
        idle();
        tick();
        total++; if (bus.r_empty !== 1'b1) $display("FAIL wrap_end_empty got %b exp 1", bus.r_empty); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            bus.w_en = 1'b1; bus.w_data = 8'h40 + 8'(i);
            tick();
        end
        rst = 1'b1; bus.w_en = 1'b1; bus.r_en = 1'b1; bus.w_data = 8'h99;
        tick();
        rst = 1'b0;
        idle();
        total++; if (bus.fill_cnt !== 4'd0) $display("FAIL rmid_cnt got %0d exp 0", bus.fill_cnt); else passed++;
        total++; if (bus.r_empty !== 1'b1) $display("FAIL rmid_empty got %b exp 1", bus.r_empty); else passed++;
        total++; if (bus.r_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", bus.r_valid); else passed++;
        total++; if (bus.r_data !== 8'h00) $display("FAIL rmid_data got %h exp 00", bus.r_data); else passed++;
        bus.w_en = 1'b1; bus.w_data = 8'h77;
        tick();
        idle();
        total++; if (bus.fill_cnt !== 4'd1) $display("FAIL rmid_refill_cnt got %0d exp 1", bus.fill_cnt); else passed++;
        bus.r_en = 1'b1;
        tick();
        idle();
        total++; if (bus.r_data !== 8'h77) $display("FAIL rmid_readback got %h exp 77", bus.r_data); else passed++;
    endtask

    initial begin
        idle();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_empty_simul();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, successor to the fixed 8-bit x 8-entry dual-clock FIFO memory wrapper. It contains its own storage array, read/write pointers and occupancy counter, so no external pointer or flag logic is needed. It adds almost-full/almost-empty thresholds, a fill-level output, a registered read with a valid strobe, and sticky overflow/underflow error flags. It is used for buffering between same-clock producer and consumer stages.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries
AFULL_TH, 6, w_afull asserts when occupancy >= AFULL_TH (range 1..DEPTH)
AEMPTY_TH, 1, r_aempty asserts when occupancy <= AEMPTY_TH (range 0..DEPTH-1)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
clr_err  input  1  synchronous clear of overflow/underflow flags
w_en  input  1  write request
w_data  input  DATA_W  write data
w_full  output  1  occupancy == DEPTH
w_afull  output  1  occupancy >= AFULL_TH
r_en  input  1  read request
r_data  output  DATA_W  registered read data
r_valid  output  1  r_data holds a newly read word this cycle
r_empty  output  1  occupancy == 0
r_aempty  output  1  occupancy <= AEMPTY_TH
fill_cnt  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst=1 at a clk edge): write and read pointers = 0, fill_cnt = 0, r_empty = 1, r_aempty = 1, w_full = 0, w_afull = 0, r_data = 0, r_valid = 0, overflow = 0, underflow = 0. Memory contents are not cleared. rst takes priority over every other input, including mid-burst traffic; data in flight is discarded.
- Write accepted (wr_ok) iff w_en & ~w_full, where w_full is the registered flag at that edge. An accepted write stores w_data at mem[wptr] and wptr increments modulo DEPTH.
- Read accepted (rd_ok) iff r_en & ~r_empty. An accepted read loads mem[rptr] into r_data at the same edge, so r_data and r_valid=1 appear the cycle after r_en is sampled (latency 1). rptr increments modulo DEPTH.
- When no read is accepted: r_valid = 0 the next cycle and r_data holds its last value.
- Simultaneous requests:
  - wr_ok & rd_ok: fill_cnt is unchanged.
  - At full: the read is accepted and the write is rejected.
  - At empty: the write is accepted and the read is rejected (no fall-through). The written word becomes readable the next cycle.
- fill_cnt: +1 on wr_ok only, -1 on rd_ok only, otherwise held. All flags are registered and computed from the next-state count, so they are valid in the same cycle as fill_cnt.
- Pointer wrap: pointers are ADDR_W bits and wrap from DEPTH-1 to 0. Full/empty are derived from fill_cnt, not from pointer compare.
- overflow is set on w_en & w_full; underflow is set on r_en & r_empty. Both hold until rst or clr_err. If clr_err and a new error occur in the same cycle, the flag stays set.
- Rejected accesses change no pointer, count or memory state.
- Storage is an inferred array with a synchronous write port and a synchronous read port on clk. Read and write addresses never collide while a read is accepted, except when fill_cnt == 0, where the read is rejected anyway.

Test Plan:
1. Reset with rst=1 for 2 cycles -> r_empty=1, r_aempty=1, w_full=0, w_afull=0, fill_cnt=0, r_valid=0, r_data=0, overflow=0, underflow=0.
2. Write 0x11..0x18 on 8 consecutive cycles (defaults) -> fill_cnt counts 1..8; w_afull rises when fill_cnt=6; w_full=1 at 8; r_aempty falls when fill_cnt=2. Then read 8 words -> r_data 0x11..0x18 in order, each with r_valid=1 one cycle after its r_en; r_empty=1 at the end.
3. With the FIFO full, assert w_en with 0xAA -> write rejected, overflow=1, fill_cnt stays 8, and the next read returns 0x11. Pulse clr_err -> overflow=0.
4. With the FIFO empty, assert w_en=1 and r_en=1 with 0x5C -> fill_cnt=1, r_valid=0, underflow=1. The next-cycle read returns 0x5C with r_valid=1.
5. Wrap and simultaneous access: preload 4 words, then drive w_en=r_en=1 for 20 cycles with an incrementing pattern -> fill_cnt stays 4 throughout, and output order matches input order across pointer wrap.
6. Reset mid-operation: with 5 words stored, assert rst alongside w_en and r_en -> next cycle fill_cnt=0, r_empty=1, r_valid=0, and no write is committed.
